// File: rtl/instr_enc_pkg.sv
// Shared op codes, MIPS opcode/funct fields and reset PC for the
// instruction encoder.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADDU = 4'h0,
    OP_SUBU = 4'h1,
    OP_ORI  = 4'h2,
    OP_LW   = 4'h3,
    OP_SW   = 4'h4,
    OP_BEQ  = 4'h5,
    OP_J    = 4'h6,
    OP_JAL  = 4'h7,
    OP_JR   = 4'h8,
    OP_LUI  = 4'h9,
    OP_LI   = 4'hA
  } op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_LUI     = 6'b001111;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  typedef enum logic {
    IDLE,
    LI_LO
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: op + register/immediate fields -> MIPS word.
// legal is low for ops it cannot encode (LI is expanded upstream).
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  always_comb begin
    instr = '0;
    legal = 1'b1;
    unique case (1'b1)
      (op == OP_ADDU):
        instr = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_ADDU};
      (op == OP_SUBU):
        instr = {OPC_SPECIAL, rs, rt, rd, 5'd0, FN_SUBU};
      (op == OP_ORI):
        instr = {OPC_ORI, rs, rt, imm[15:0]};
      (op == OP_LW):
        instr = {OPC_LW, rs, rt, imm[15:0]};
      (op == OP_SW):
        instr = {OPC_SW, rs, rt, imm[15:0]};
      (op == OP_BEQ):
        instr = {OPC_BEQ, rs, rt, imm[15:0]};
      (op == OP_J):
        instr = {OPC_J, imm};
      (op == OP_JAL):
        instr = {OPC_JAL, imm};
      (op == OP_JR):
        instr = {OPC_SPECIAL, rs, 15'd0, FN_JR};
      (op == OP_LUI):
        instr = {OPC_LUI, 5'd0, rt, imm[15:0]};
      default:
        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder with PC tracking.
// Define LI_EXPAND_EN to expand the LI pseudo-op into lui/ori.
module instr_encoder
  import instr_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        err
);

  logic [3:0]  p_op;
  logic [4:0]  p_rs;
  logic [4:0]  p_rt;
  logic [25:0] p_imm;
  logic [31:0] p_word;
  logic        p_legal;
  logic        acc;
  logic        out_hs;
  logic        load_lo;

  assign acc    = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

`ifdef LI_EXPAND_EN
  state_e      state_q;
  state_e      state_d;
  logic [4:0]  li_rt;
  logic [15:0] li_lo;
  logic        li_hi;

  assign li_hi    = (in_op == OP_LI) && (in_imm[31:16] != 16'h0);
  assign in_ready = (state_q == IDLE) & (!out_valid | out_ready);
  assign load_lo  = (state_q == LI_LO) & out_hs;

  // LI is rewritten to lui/ori here so the packer never sees it
  always_comb begin
    state_d = state_q;
    p_op    = in_op;
    p_rs    = in_rs;
    p_rt    = in_rt;
    p_imm   = in_imm[25:0];
    unique case (state_q)
      IDLE: begin
        if (in_op == OP_LI) begin
          p_op  = li_hi ? OP_LUI : OP_ORI;
          p_rs  = 5'd0;
          p_imm = {10'd0, li_hi ? in_imm[31:16] : in_imm[15:0]};
        end
        if (acc && li_hi) state_d = LI_LO;
      end
      LI_LO: begin
        p_op  = OP_ORI;
        p_rs  = li_rt;
        p_rt  = li_rt;
        p_imm = {10'd0, li_lo};
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      li_rt   <= '0;
      li_lo   <= '0;
    end else begin
      state_q <= state_d;
      if (acc && li_hi) begin
        li_rt <= in_rt;
        li_lo <= in_imm[15:0];
      end
    end
  end
`else
  logic unused_imm;

  assign unused_imm = ^in_imm[31:26];
  assign in_ready   = !out_valid | out_ready;
  assign load_lo    = 1'b0;
  assign p_op       = in_op;
  assign p_rs       = in_rs;
  assign p_rt       = in_rt;
  assign p_imm      = in_imm[25:0];
`endif

  instr_pack u_pack (
    .op    (p_op),
    .rs    (p_rs),
    .rt    (p_rt),
    .rd    (in_rd),
    .imm   (p_imm),
    .instr (p_word),
    .legal (p_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= PC_RESET;
      err       <= 1'b0;
    end else begin
      err <= acc & !p_legal;
      if (out_hs) out_pc <= out_pc + 32'd4;
      if (load_lo || (acc && p_legal)) begin
        out_valid <= 1'b1;
        out_instr <= p_word;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random
// traffic against a word-queue reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic [31:0] exp_pc  = 32'h3000;
  logic        exp_err = 1'b0;

`ifdef LI_EXPAND_EN
  localparam bit LI_EN = 1'b1;
`else
  localparam bit LI_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fi(int opc, logic [4:0] rs,
                                     logic [4:0] rt, logic [15:0] k);
    return (32'(opc) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(k);
  endfunction

  // Reference: append the word(s) an accepted request produces
  function automatic bit push_words(logic [3:0] op, logic [4:0] rs,
                                    logic [4:0] rt, logic [4:0] rd,
                                    logic [31:0] imm);
    logic [31:0] r;
    r = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11);
    case (op)
      4'h0: q.push_back(r + 32'd33);
      4'h1: q.push_back(r + 32'd35);
      4'h2: q.push_back(fi(13, rs, rt, imm[15:0]));
      4'h3: q.push_back(fi(35, rs, rt, imm[15:0]));
      4'h4: q.push_back(fi(43, rs, rt, imm[15:0]));
      4'h5: q.push_back(fi(4, rs, rt, imm[15:0]));
      4'h6: q.push_back((32'd2 << 26) + 32'(imm[25:0]));
      4'h7: q.push_back((32'd3 << 26) + 32'(imm[25:0]));
      4'h8: q.push_back((32'(rs) << 21) + 32'd8);
      4'h9: q.push_back(fi(15, 5'd0, rt, imm[15:0]));
      4'hA: begin
        if (!LI_EN) return 1'b0;
        if (imm[31:16] != 16'h0) begin
          q.push_back(fi(15, 5'd0, rt, imm[31:16]));
          q.push_back(fi(13, rt, rt, imm[15:0]));
        end else begin
          q.push_back(fi(13, 5'd0, rt, imm[15:0]));
        end
      end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Check outputs mid-cycle, advance the model, then cross the edge
  task automatic step();
    logic rdy;
    logic nerr;
    @(negedge clk);
    rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("err", 32'(err), 32'(exp_err));
    chk("out_pc", out_pc, exp_pc);
    if (q.size() != 0) chk("out_instr", out_instr, q[0]);
    nerr = 1'b0;
    if (q.size() != 0 && out_ready) begin
      void'(q.pop_front());
      exp_pc += 32'd4;
    end
    if (in_valid && rdy)
      nerr = !push_words(in_op, in_rs, in_rt, in_rd, in_imm);
    exp_err = nerr;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc  = 32'h3000;
    exp_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h3000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic req(input logic [3:0] op, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] s_i;
    logic [31:0] s_p;

    @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_pc", out_pc, 32'h3000);
    chk("reset_instr", out_instr, 32'h0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    out_ready = 1'b0;
    req(4'h0, 5'd1, 5'd2, 5'd3, 32'h0);
    chk("addu_word", out_instr, 32'h00221821);
    chk("addu_pc", out_pc, 32'h3000);
    out_ready = 1'b1;
    step();

    req(4'h7, 5'd0, 5'd0, 5'd0, 32'h0000_0C03);
    chk("jal_word", out_instr, 32'h0C000C03);
    step();

`ifdef LI_EXPAND_EN
    do_reset();
    out_ready = 1'b0;
    req(4'hA, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    chk("li_lui_word", out_instr, 32'h3C081234);
    chk("li_lui_pc", out_pc, 32'h3000);
    chk("li_busy_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    chk("li_lo_ready", 32'(in_ready), 32'd0);
    step();
    chk("li_ori_word", out_instr, 32'h35085678);
    chk("li_ori_pc", out_pc, 32'h3004);
    step();
    req(4'hA, 5'd0, 5'd9, 5'd0, 32'h0000_BEEF);
    chk("li_short_word", out_instr, 32'h3409BEEF);
    step();
    chk("li_short_single", 32'(out_valid), 32'd0);
`else
    req(4'hA, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    chk("li_off_err", 32'(err), 32'd1);
    chk("li_off_valid", 32'(out_valid), 32'd0);
    step();
`endif

    s_p = exp_pc;
    out_ready = 1'b1;
    req(4'hF, 5'd1, 5'd1, 5'd1, 32'h0);
    chk("ill_err_hi", 32'(err), 32'd1);
    chk("ill_valid", 32'(out_valid), 32'd0);
    step();
    chk("ill_err_lo", 32'(err), 32'd0);
    chk("ill_valid2", 32'(out_valid), 32'd0);
    req(4'h1, 5'd4, 5'd5, 5'd6, 32'h0);
    chk("ill_next_pc", out_pc, s_p);
    step();

    out_ready = 1'b0;
    req(4'h3, 5'd7, 5'd10, 5'd0, 32'h0000_FFFC);
    s_i = out_instr;
    s_p = out_pc;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", out_instr, s_i);
      chk("stall_pc", out_pc, s_p);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();

`ifdef LI_EXPAND_EN
    out_ready = 1'b0;
    req(4'hA, 5'd0, 5'd3, 5'd0, 32'hABCD_0001);
    reset = 1'b1;
    #1;
    model_reset();
    chk("li_rst_valid", 32'(out_valid), 32'd0);
    chk("li_rst_pc", out_pc, 32'h3000);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
`endif

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) in_op = 4'($urandom_range(0, 10));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = $urandom;
      if ($urandom_range(0, 1) != 0) in_imm[31:16] = 16'h0;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
